trng_sampler: RTL and testbench

- Consumer end of the ring-oscillator entropy source. It synchronizes one raw RO output bit and samples it on a programmable tick.
- Von Neumann debiasing removes bias; the surviving bits are packed into bytes and buffered in a small FWFT FIFO with a valid/ready output.
- A repetition-count health test guards the raw stream. Sits between the RO core and the tile output/readout logic.

---
 rtl/trng_sampler_pkg.sv | 20 ++
 rtl/trng_sampler_if.sv | 17 +
 rtl/trng_sampler_byte_fifo.sv | 91 +++++++++
 rtl/trng_sampler.sv | 225 ++++++++++++++++++++++
 tb/tb_trng_sampler.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_sampler_pkg.sv
// Shared types and constants for the ring-oscillator entropy sampler.
// FSM state encoding, byte width and the LSB-first packing helper.
package trng_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_A     = 2'd1,
        S_B     = 2'd2,
        S_FAULT = 2'd3
    } trng_state_e;

    // New bits enter at the top so the first bit of a byte ends up in bit 0.
    function automatic logic [BYTE_W-1:0] pack_lsb_first(input logic [BYTE_W-1:0] shift_v,
                                                         input logic bit_v);
        return {bit_v, shift_v[BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/trng_sampler_if.sv
// Byte readout channel of the entropy sampler: FWFT head byte, valid/ready and occupancy.
interface trng_sampler_if #(
    parameter int FIFO_DEPTH = 4
);
    import trng_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic [CNT_W-1:0]  fifo_count;

    modport master (output dout, output dout_valid, output fifo_count, input dout_ready);
    modport slave  (input dout, input dout_valid, input fifo_count, output dout_ready);

endinterface

// File: rtl/trng_sampler_byte_fifo.sv
// First-word fall-through byte FIFO with registered head/valid/count/full.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trng_byte_fifo
    import trng_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic [BYTE_W-1:0] head,
    output logic              valid
);

    logic [BYTE_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              full_r;
    logic              valid_r;
    logic [BYTE_W-1:0] head_r;

    logic              pop_ok_s;
    logic              push_ok_s;
    logic [AW-1:0]     rd_next_s;
    logic [CW-1:0]     count_next_s;
    logic [BYTE_W-1:0] head_next_s;

    // Next pointers, occupancy and the byte that will sit at the head next cycle.
    always_comb begin
        pop_ok_s  = pop && valid_r;
        push_ok_s = push && (!full_r || pop_ok_s);
        if (pop_ok_s) begin
            rd_next_s = rd_ptr_r + AW'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
        // Write slot equals the next head only when the FIFO would otherwise be empty.
        if (count_next_s == CW'(0)) begin
            head_next_s = {BYTE_W{1'b0}};
        end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = din;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage, pointers and registered status.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {BYTE_W{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
            head_r   <= {BYTE_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CW'(DEPTH));
            valid_r  <= (count_next_s != CW'(0));
            head_r   <= head_next_s;
        end
    end

    assign full  = full_r;
    assign count = count_r;
    assign head  = head_r;
    assign valid = valid_r;

endmodule

// File: rtl/trng_sampler.sv
// RO entropy sampler: synchronize, strobe-sample, Von Neumann debias, pack bytes, RCT health test.
// Optional raw bypass input is enabled by defining TRNG_SAMPLER_RAW_BYPASS_EN.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int RCT_CUTOFF  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  raw_bit,
    input  logic                  clear_fail,
`ifdef TRNG_SAMPLER_RAW_BYPASS_EN
    input  logic                  bypass,
`endif
    trng_sampler_if.master        out_if,
    output logic                  health_fail,
    output logic                  overflow
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int RUN_W  = $clog2(RCT_CUTOFF + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [TICK_W-1:0]      tick_r;
    trng_state_e            state_r;
    logic                   a_r;
    logic                   prev_r;
    logic [RUN_W-1:0]       run_r;
    logic [BYTE_W-1:0]      shift_r;
    logic [2:0]             bit_cnt_r;
    logic                   health_fail_r;
    logic                   overflow_r;

    logic                   bypass_s;
    logic                   strobe_s;
    logic                   sample_s;
    logic [RUN_W-1:0]       run_inc_s;
    logic [RUN_W-1:0]       run_next_s;
    logic                   trip_s;
    logic                   emit_s;
    logic                   emit_bit_s;
    logic                   push_s;
    logic [BYTE_W-1:0]      push_byte_s;
    logic                   pop_s;
    logic                   drop_s;
    logic                   fifo_full_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic [BYTE_W-1:0]      fifo_head_s;
    logic                   fifo_valid_s;

`ifdef TRNG_SAMPLER_RAW_BYPASS_EN
    assign bypass_s = bypass;
`else
    assign bypass_s = 1'b0;
`endif

    // Strobe, repetition-count lookahead, debiaser emission and FIFO handshake.
    always_comb begin
        strobe_s = en && (tick_r == TICK_W'(SAMPLE_DIV - 1));
        sample_s = sync_r[SYNC_STAGES-1];
        if (run_r == RUN_W'(RCT_CUTOFF)) begin
            run_inc_s = run_r;
        end else begin
            run_inc_s = run_r + RUN_W'(1);
        end
        if (sample_s == prev_r) begin
            run_next_s = run_inc_s;
        end else begin
            run_next_s = RUN_W'(1);
        end
        // A clear in the same cycle suppresses the trip.
        trip_s = strobe_s && (state_r != S_FAULT) && (run_next_s >= RUN_W'(RCT_CUTOFF))
                 && !clear_fail;
        emit_s     = 1'b0;
        emit_bit_s = 1'b0;
        if (strobe_s && !trip_s) begin
            if (bypass_s && ((state_r == S_A) || (state_r == S_B))) begin
                emit_s     = 1'b1;
                emit_bit_s = sample_s;
            end else if ((state_r == S_B) && (a_r != sample_s)) begin
                emit_s     = 1'b1;
                emit_bit_s = a_r;
            end else begin
                emit_s     = 1'b0;
                emit_bit_s = 1'b0;
            end
        end else begin
            emit_s     = 1'b0;
            emit_bit_s = 1'b0;
        end
        push_s      = emit_s && (bit_cnt_r == 3'd7);
        push_byte_s = pack_lsb_first(shift_r, emit_bit_s);
        pop_s       = fifo_valid_s && out_if.dout_ready;
        drop_s      = push_s && fifo_full_s && !pop_s;
    end

    // Raw-bit synchronizer and sample tick counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            tick_r <= {TICK_W{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_bit};
            if (!en || (tick_r == TICK_W'(SAMPLE_DIV - 1))) begin
                tick_r <= {TICK_W{1'b0}};
            end else begin
                tick_r <= tick_r + TICK_W'(1);
            end
        end
    end

    // Debias FSM: arms on the first strobe, then alternates between the two halves of a pair.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= S_IDLE;
            a_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (trip_s) begin
                        state_r <= S_FAULT;
                    end else if (strobe_s) begin
                        state_r <= S_A;
                    end
                end
                S_A: begin
                    if (trip_s) begin
                        state_r <= S_FAULT;
                    end else if (!en) begin
                        state_r <= S_IDLE;
                    end else if (strobe_s && !bypass_s) begin
                        a_r     <= sample_s;
                        state_r <= S_B;
                    end
                end
                S_B: begin
                    if (trip_s) begin
                        state_r <= S_FAULT;
                    end else if (!en) begin
                        state_r <= S_IDLE;
                    end else if (strobe_s) begin
                        state_r <= S_A;
                    end
                end
                S_FAULT: begin
                    if (clear_fail) begin
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Byte packer; a partial byte survives en dropping but not a health trip.
    always_ff @(posedge clk) begin
        if (rst_n || trip_s) begin
            shift_r   <= {BYTE_W{1'b0}};
            bit_cnt_r <= 3'd0;
        end else if (emit_s) begin
            if (bit_cnt_r == 3'd7) begin
                shift_r   <= {BYTE_W{1'b0}};
                bit_cnt_r <= 3'd0;
            end else begin
                shift_r   <= push_byte_s;
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

    // Repetition-count test and sticky status flags; clear_fail takes priority.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            prev_r        <= 1'b0;
            run_r         <= {RUN_W{1'b0}};
            health_fail_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            if (strobe_s) begin
                prev_r <= sample_s;
            end
            if (clear_fail) begin
                run_r         <= {RUN_W{1'b0}};
                health_fail_r <= 1'b0;
                overflow_r    <= 1'b0;
            end else begin
                if (strobe_s) begin
                    run_r <= run_next_s;
                end
                if (trip_s) begin
                    health_fail_r <= 1'b1;
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    trng_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (push_byte_s),
        .pop   (pop_s),
        .full  (fifo_full_s),
        .count (fifo_count_s),
        .head  (fifo_head_s),
        .valid (fifo_valid_s)
    );

    assign out_if.dout       = fifo_head_s;
    assign out_if.dout_valid = fifo_valid_s;
    assign out_if.fifo_count = fifo_count_s;
    assign health_fail       = health_fail_r;
    assign overflow          = overflow_r;

endmodule

// File: tb/tb_trng_sampler.sv
// Self-checking bench for trng_sampler: randomized raw stream against a sample-level reference model.
module tb_trng_sampler;

    localparam int SYNC  = 2;
    localparam int DIV   = 1;
    localparam int DEPTH = 4;
    localparam int CUT   = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic raw_bit = 1'b0;
    logic clear_fail = 1'b0;
    logic health_fail;
    logic overflow;
`ifdef TRNG_SAMPLER_RAW_BYPASS_EN
    logic bypass = 1'b0;
`endif

    trng_sampler_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

    trng_sampler #(
        .SYNC_STAGES (SYNC),
        .SAMPLE_DIV  (DIV),
        .FIFO_DEPTH  (DEPTH),
        .RCT_CUTOFF  (CUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .raw_bit     (raw_bit),
        .clear_fail  (clear_fail),
`ifdef TRNG_SAMPLER_RAW_BYPASS_EN
        .bypass      (bypass),
`endif
        .out_if      (bus_if),
        .health_fail (health_fail),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: sample history, pairing flags, bit queue and byte queue.
    bit         m_raw[$];
    int         m_tick;
    bit         m_armed, m_have_a, m_a, m_failed, m_ovf, m_prev;
    int         m_run;
    bit         m_bits[$];
    logic [7:0] m_fifo[$];
    bit         m_pushed;
    bit         m_push_ok;
    logic [7:0] m_push_byte;

    task automatic model_reset();
        m_raw.delete();
        for (int i = 0; i < SYNC; i++) m_raw.push_back(1'b0);
        m_tick = 0; m_armed = 0; m_have_a = 0; m_a = 0; m_failed = 0; m_ovf = 0;
        m_prev = 0; m_run = 0; m_bits.delete(); m_fifo.delete();
    endtask

    task automatic model_edge();
        bit strobe, smp, pop, trip, emit, eb;
        int run_n;
        logic [7:0] byte_v;
        m_pushed = 0; m_push_ok = 0;
        if (rst_n) begin
            model_reset();
            return;
        end
        strobe = en && (m_tick == DIV - 1);
        m_tick = (!en || m_tick == DIV - 1) ? 0 : m_tick + 1;
        smp = m_raw[SYNC-1];
        m_raw.push_front(raw_bit);
        void'(m_raw.pop_back());
        pop = (m_fifo.size() != 0) && bus_if.dout_ready;
        trip = 0; emit = 0; eb = 0; run_n = m_run;
        if (strobe) begin
            run_n = (smp == m_prev) ? ((m_run + 1 > CUT) ? CUT : m_run + 1) : 1;
            m_prev = smp;
            if (!m_failed && run_n >= CUT && !clear_fail) trip = 1;
        end
        m_run = clear_fail ? 0 : run_n;
        if (trip) begin
            m_failed = 1;
            m_bits.delete();
        end else if (!m_failed) begin
            if (!en) begin
                m_armed = 0; m_have_a = 0;
            end else if (strobe) begin
                if (!m_armed) begin
                    m_armed = 1; m_have_a = 0;
                end else if (!m_have_a) begin
                    m_a = smp; m_have_a = 1;
                end else begin
                    if (m_a != smp) begin emit = 1; eb = m_a; end
                    m_have_a = 0;
                end
            end
        end
        if (clear_fail && m_failed) begin
            m_failed = 0; m_armed = 0; m_have_a = 0;
        end
        if (emit) begin
            m_bits.push_back(eb);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++) byte_v[i] = m_bits[i];
                m_bits.delete();
                m_pushed = 1;
                m_push_byte = byte_v;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (m_pushed) begin
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(m_push_byte);
                m_push_ok = 1;
            end else if (!clear_fail) begin
                m_ovf = 1;
            end
        end
        if (clear_fail) m_ovf = 0;
    endtask

    // Predicts whether the next edge completes a byte (assumes clear_fail low).
    function automatic bit will_push(input bit e);
        bit smp;
        int run_n;
        smp = m_raw[SYNC-1];
        if (!(e && m_tick == DIV - 1) || m_failed || !m_armed || !m_have_a || m_bits.size() != 7)
            return 1'b0;
        run_n = (smp == m_prev) ? ((m_run + 1 > CUT) ? CUT : m_run + 1) : 1;
        if (run_n >= CUT) return 1'b0;
        return m_a != smp;
    endfunction

    task automatic cyc(input bit e, input bit r, input bit c, input bit rdy);
        en = e; raw_bit = r; clear_fail = c; bus_if.dout_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [CW+2:0] got;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b0;
        got = {bus_if.dout_valid, bus_if.fifo_count, health_fail, overflow};
        n_checks++;
        if (got !== '0) $display("FAIL reset_status: got %b expected 0", got);
        else n_pass++;
        n_checks++;
        if (bus_if.dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", bus_if.dout);
        else n_pass++;
    endtask

    task automatic test_pattern();
        bit p[24] = '{0,1, 1,0, 1,0, 0,1, 0,0, 1,1, 0,1, 0,1, 1,0, 1,0, 1,0, 0,1};
        for (int i = 0; i < 26; i++) begin
            cyc(i >= 1, (i < 24) ? p[i] : 1'b0, 0, 0);
            n_checks++;
            if (bus_if.fifo_count !== CW'(m_fifo.size()))
                $display("FAIL pattern_count: cycle %0d got %0d expected %0d", i, bus_if.fifo_count, m_fifo.size());
            else n_pass++;
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if ({bus_if.dout_valid, bus_if.fifo_count} !== {1'b1, CW'(1)})
            $display("FAIL pattern_valid: got %b/%0d expected 1/1", bus_if.dout_valid, bus_if.fifo_count);
        else n_pass++;
        n_checks++;
        if (bus_if.dout !== 8'hC6) $display("FAIL pattern_byte: got %h expected c6", bus_if.dout);
        else n_pass++;
        cyc(0, 0, 0, 1);
        n_checks++;
        if (bus_if.dout_valid !== 1'b0) $display("FAIL pattern_drain: got valid %b expected 0", bus_if.dout_valid);
        else n_pass++;
    endtask

    task automatic test_rct();
        int guard;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 0);
            n_checks++;
            if (health_fail !== m_failed)
                $display("FAIL rct_model: cycle %0d got %b expected %b", i, health_fail, m_failed);
            else n_pass++;
            // edge 0 arms, edges 0-1 still see old zeros, edge 33 is the 32nd strobe of ones
            if (i == 32 || i == 33) begin
                n_checks++;
                if (health_fail !== (i == 33))
                    $display("FAIL rct_trip_edge: cycle %0d got %b expected %b", i, health_fail, i == 33);
                else n_pass++;
            end
        end
        n_checks++;
        if (bus_if.fifo_count !== CW'(0)) $display("FAIL rct_no_push: got %0d expected 0", bus_if.fifo_count);
        else n_pass++;
        cyc(1, 1, 1, 0);
        n_checks++;
        if ({health_fail, overflow} !== 2'b00) $display("FAIL rct_clear: got %b expected 00", {health_fail, overflow});
        else n_pass++;
        guard = 0;
        while (m_fifo.size() == 0 && guard < 2000) begin
            cyc(1, 1'($urandom_range(0, 1)), 0, 0);
            guard++;
        end
        n_checks++;
        if (guard >= 2000 || bus_if.dout_valid !== 1'b1 || bus_if.dout !== m_fifo[0])
            $display("FAIL rct_resume: got %b/%h expected 1/%h", bus_if.dout_valid, bus_if.dout, m_fifo[0]);
        else n_pass++;
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        logic [7:0] pushed[$];
        int guard = 0;
        while (pushed.size() < 5 && guard < 3000) begin
            cyc(1, 1'($urandom_range(0, 1)), 0, 0);
            if (m_pushed) pushed.push_back(m_push_byte);
            guard++;
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if (guard >= 3000 || {bus_if.fifo_count, overflow} !== {CW'(4), 1'b1})
            $display("FAIL overflow_flag: got %0d/%b expected 4/1", bus_if.fifo_count, overflow);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus_if.dout_valid !== 1'b1 || bus_if.dout !== pushed[k])
                $display("FAIL overflow_order: byte %0d got %b/%h expected 1/%h", k, bus_if.dout_valid, bus_if.dout, pushed[k]);
            else n_pass++;
            cyc(0, 0, 0, 1);
        end
        cyc(0, 0, 1, 0);
        n_checks++;
        if ({overflow, bus_if.fifo_count} !== {1'b0, CW'(0)})
            $display("FAIL overflow_clear: got %b/%0d expected 0/0", overflow, bus_if.fifo_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        bit wp, done = 0;
        logic [7:0] newest;
        bit r;
        while (!done && guard < 4000) begin
            r = 1'($urandom_range(0, 1));
            wp = (m_fifo.size() == DEPTH) && will_push(1'b1);
            cyc(1, r, 0, wp);
            if (wp) begin done = 1; newest = m_push_byte; end
            guard++;
        end
        cyc(0, 0, 0, 0);
        n_checks++;
        if (!done || {bus_if.fifo_count, overflow} !== {CW'(4), 1'b0})
            $display("FAIL b2b_count: got %0d/%b expected 4/0", bus_if.fifo_count, overflow);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (bus_if.dout !== m_fifo[0]) $display("FAIL b2b_order: byte %0d got %h expected %h", k, bus_if.dout, m_fifo[0]);
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if (bus_if.dout !== newest) $display("FAIL b2b_last: got %h expected %h", bus_if.dout, newest);
                else n_pass++;
            end
            cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_en_drop();
        int guard = 0;
        logic [2:0] keep;
        while (!(m_bits.size() == 3 && m_have_a && !m_failed) && guard < 3000) begin
            cyc(1, 1'($urandom_range(0, 1)), 0, 1);
            guard++;
        end
        keep = {m_bits[2], m_bits[1], m_bits[0]};
        for (int i = 0; i < 3; i++) cyc(0, 1'($urandom_range(0, 1)), 0, 1);
        while (m_fifo.size() == 0 && guard < 6000) begin
            cyc(1, 1'($urandom_range(0, 1)), 0, 0);
            guard++;
        end
        n_checks++;
        if (guard >= 6000 || bus_if.dout[2:0] !== keep)
            $display("FAIL en_drop_bits: got %b expected %b", bus_if.dout[2:0], keep);
        else n_pass++;
        n_checks++;
        if (bus_if.dout !== m_fifo[0]) $display("FAIL en_drop_byte: got %h expected %h", bus_if.dout, m_fifo[0]);
        else n_pass++;
        cyc(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        logic [CW+2:0] got;
        while (!(m_fifo.size() == 2 && m_bits.size() > 0) && guard < 4000) begin
            cyc(1, 1'($urandom_range(0, 1)), 0, 0);
            guard++;
        end
        n_checks++;
        if (guard >= 4000 || bus_if.fifo_count !== CW'(2))
            $display("FAIL midreset_setup: got %0d expected 2", bus_if.fifo_count);
        else n_pass++;
        rst_n = 1'b1;
        cyc(1, 1'($urandom_range(0, 1)), 0, 0);
        rst_n = 1'b0;
        got = {bus_if.dout_valid, bus_if.fifo_count, health_fail, overflow};
        n_checks++;
        if (got !== '0 || bus_if.dout !== 8'h00)
            $display("FAIL midreset_outputs: got %b/%h expected 0/00", got, bus_if.dout);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [CW+2:0] got, exp;
        bit hold_v = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 < 45) hold_v = (i % 800) < 400;
            else hold_v = 1'($urandom_range(0, 1));
            cyc(($urandom_range(0, 15) != 0), hold_v, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
            got = {bus_if.dout_valid, bus_if.fifo_count, health_fail, overflow};
            exp = {m_fifo.size() != 0, CW'(m_fifo.size()), m_failed, m_ovf};
            n_checks++;
            if (got !== exp) $display("FAIL random_status: cycle %0d got %b expected %b", i, got, exp);
            else n_pass++;
            if (m_fifo.size() != 0) begin
                n_checks++;
                if (bus_if.dout !== m_fifo[0]) $display("FAIL random_dout: cycle %0d got %h expected %h", i, bus_if.dout, m_fifo[0]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus_if.dout_ready = 1'b0;
        model_reset();
        test_reset();
        test_pattern();
        test_rct();
        test_overflow();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
